// File: rtl/mode_scheduler_if.sv
// mode_scheduler_if: board I/O, mode-block panel feeds and muxed panel outputs of the mode scheduler
interface mode_scheduler_if;
  logic        push_button_mode;
  logic        alarm_enable;
  logic [11:0] current_time;
  logic [11:0] alarm_time;
  logic [1:0]  minigame_activated;
  logic [27:0] seg_in;
  logic [15:0] anode_in;
  logic [39:0] led_in;
  logic [3:0]  ENABLE;
  logic [1:0]  active_mode;
  logic        alarm_pending;
  logic [6:0]  SEG;
  logic [3:0]  ANODE;
  logic [9:0]  LED;
  modport slave (
    input  push_button_mode, alarm_enable, current_time, alarm_time, minigame_activated,
           seg_in, anode_in, led_in,
    output ENABLE, active_mode, alarm_pending, SEG, ANODE, LED
  );
  modport master (
    output push_button_mode, alarm_enable, current_time, alarm_time, minigame_activated,
           seg_in, anode_in, led_in,
    input  ENABLE, active_mode, alarm_pending, SEG, ANODE, LED
  );
endinterface

// File: rtl/mode_scheduler.sv
// mode_scheduler: debounced mode cycling, alarm preemption into mode 4 with restore, panel mux
module mode_scheduler #(
  parameter int DEBOUNCE_MS = 20,
  parameter int WATCHDOG_MS = 5000
) (
  input logic             CLOCK_1ms,
  input logic             RESET,
  mode_scheduler_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int WW = $clog2(WATCHDOG_MS);
  localparam logic [1:0] NORMAL  = 2'd0;
  localparam logic [1:0] ALARM   = 2'd1;
  localparam logic [1:0] RESTORE = 2'd2;
  logic          meta_q, sync_q, lvl_q, lvl_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d, sel_q, sel_d, saved_q, saved_d;
  logic          seen_q, seen_d, fired_q, fired_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    en_q, an_q;
  logic [1:0]    act_q, prev_q;
  logic          pend_q;
  logic [6:0]    seg_q;
  logic [9:0]    led_q;
  logic          flip, press, match, trig;
  always_comb begin
    flip    = (sync_q != lvl_q) && (cnt_q == DW'(DEBOUNCE_MS - 1));
    lvl_d   = flip ? sync_q : lvl_q;
    cnt_d   = (sync_q == lvl_q || flip) ? '0 : cnt_q + 1'b1;
    press   = flip && sync_q;
    match   = bus.alarm_enable && (bus.current_time == bus.alarm_time);
    trig    = (state_q == NORMAL) && match && !fired_q;
    fired_d = !match ? 1'b0 : (trig ? 1'b1 : fired_q);
    state_d = state_q;
    sel_d   = sel_q;
    saved_d = saved_q;
    seen_d  = seen_q;
    wd_d    = wd_q;
    if (state_q == NORMAL) begin
      // a trigger in the same cycle as a press wins and the press is dropped
      if (trig) begin
        saved_d = sel_q;
        sel_d   = 2'd3;
        seen_d  = 1'b0;
        wd_d    = '0;
        state_d = ALARM;
      end else if (press) begin
        sel_d = sel_q + 2'd1;
      end
    end else if (state_q == ALARM) begin
      if (bus.minigame_activated != 2'b00) begin
        seen_d = 1'b1;
        wd_d   = '0;
      end else if (seen_q || wd_q == WW'(WATCHDOG_MS - 1)) begin
        state_d = RESTORE;
      end else begin
        wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
      end
    end else begin
      sel_d   = saved_q;
      state_d = NORMAL;
    end
  end
  always_ff @(posedge CLOCK_1ms) begin
    if (RESET) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= NORMAL;
      sel_q   <= 2'd0;
      saved_q <= 2'd0;
      seen_q  <= 1'b0;
      fired_q <= 1'b0;
      wd_q    <= '0;
      en_q    <= 4'b0001;
      act_q   <= 2'd0;
      prev_q  <= 2'd0;
      pend_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
      led_q   <= 10'd0;
    end else begin
      meta_q  <= bus.push_button_mode;
      sync_q  <= meta_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      saved_q <= saved_d;
      seen_q  <= seen_d;
      fired_q <= fired_d;
      wd_q    <= wd_d;
      en_q    <= 4'b0001 << sel_q;
      act_q   <= sel_q;
      prev_q  <= act_q;
      pend_q  <= (state_q == ALARM);
      // blank for one frame after a switch so the outgoing mode never shows under the new enable
      seg_q   <= (act_q != prev_q) ? 7'h7F : bus.seg_in[7*act_q +: 7];
      an_q    <= (act_q != prev_q) ? 4'hF : bus.anode_in[4*act_q +: 4];
      led_q   <= (act_q != prev_q) ? 10'd0 : bus.led_in[10*act_q +: 10];
    end
  end
  assign bus.ENABLE        = en_q;
  assign bus.active_mode   = act_q;
  assign bus.alarm_pending = pend_q;
  assign bus.SEG           = seg_q;
  assign bus.ANODE         = an_q;
  assign bus.LED           = led_q;
endmodule
